bp_lce_resp_arbiter: RTL and testbench

//   Parametrised N-source arbiter for LCE->CCE response packets; generalises the

---
 rtl/bp_lce_resp_arbiter.sv | 142 ++++++++++++++
 tb/tb_bp_lce_resp_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_resp_arbiter.sv
// N-source LCE->CCE response arbiter: one private FIFO per source feeding a
// round-robin or fixed-priority arbiter whose grant is held until the beat is accepted.
module bp_lce_resp_arbiter #(
  parameter int unsigned num_src_p    = 2,
  parameter int unsigned resp_width_p = 64,
  parameter int unsigned buf_els_p    = 2,
  parameter int unsigned rr_p         = 1,
  localparam int unsigned IdWidth     = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*resp_width_p-1:0] resp_i,
  input  logic [num_src_p-1:0]              resp_v_i,
  output logic [num_src_p-1:0]              resp_ready_o,
  output logic [resp_width_p-1:0]           lce_resp_o,
  output logic                              lce_resp_v_o,
  input  logic                              lce_resp_ready_i,
  output logic [IdWidth-1:0]                grant_id_o
);

  localparam int unsigned PtrWidth = $clog2(buf_els_p);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [resp_width_p-1:0] mem_q  [num_src_p][buf_els_p];
  logic [PtrWidth-1:0]     wptr_q [num_src_p];
  logic [PtrWidth-1:0]     rptr_q [num_src_p];
  logic [CntWidth-1:0]     cnt_q  [num_src_p];

  logic [num_src_p-1:0] full, nonempty, enq, deq;
  logic [IdWidth-1:0]   sel, grant;
  logic                 handshake;

  logic               lock_q, lock_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;
  logic [IdWidth-1:0] last_q, last_d;

  always_comb begin
    for (int i = 0; i < int'(num_src_p); i++) begin
      full[i]     = (cnt_q[i] == CntWidth'(buf_els_p));
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // Ready comes from the registered count only, so a full FIFO never bypasses.
  assign resp_ready_o = ~full & {num_src_p{~reset_i}};
  assign enq          = resp_v_i & resp_ready_o;

  always_comb begin
    int  idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    if (rr_p != 0) begin
      for (int k = 1; k <= int'(num_src_p); k++) begin
        idx = (int'(last_q) + k) % int'(num_src_p);
        if (!found && nonempty[idx]) begin
          sel   = IdWidth'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < int'(num_src_p); k++) begin
        if (!found && nonempty[k]) begin
          sel   = IdWidth'(k);
          found = 1'b1;
        end
      end
    end
  end

  assign grant        = lock_q ? lock_id_q : sel;
  assign grant_id_o   = (num_src_p == 1) ? '0 : grant;
  assign lce_resp_v_o = ~reset_i & (lock_q | (|nonempty));
  assign handshake    = lce_resp_v_o & lce_resp_ready_i;

  always_comb begin
    lce_resp_o = '0;
    deq        = '0;
    for (int i = 0; i < int'(num_src_p); i++) begin
      if (grant == IdWidth'(i)) begin
        lce_resp_o = mem_q[i][rptr_q[i]];
        deq[i]     = handshake;
      end
    end
  end

  always_comb begin
    lock_d    = lce_resp_v_o & ~lce_resp_ready_i;
    lock_id_d = grant;
    last_d    = (handshake && rr_p != 0) ? grant : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      last_q    <= IdWidth'(num_src_p - 1);
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(num_src_p); i++) begin
      if (reset_i) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end else begin
        if (enq[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (deq[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
        unique case ({enq[i], deq[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(num_src_p); i++) begin
      if (enq[i]) mem_q[i][wptr_q[i]] <= resp_i[i*resp_width_p +: resp_width_p];
    end
  end

  for (genvar g = 0; g < int'(num_src_p); g++) begin : g_fifo_chk
    a_no_enq_full : assert property (@(posedge clk_i) disable iff (reset_i)
      !(enq[g] && full[g]));
    a_no_deq_empty : assert property (@(posedge clk_i) disable iff (reset_i)
      !(deq[g] && !nonempty[g]));
  end

  a_hold_stable : assert property (@(posedge clk_i) disable iff (reset_i)
    (lce_resp_v_o && !lce_resp_ready_i) |=>
      (lce_resp_v_o && $stable(lce_resp_o) && $stable(grant_id_o)));

endmodule

// File: tb/tb_bp_lce_resp_arbiter.sv
// Directed bench for bp_lce_resp_arbiter: two-source round-robin and fixed-priority
// instances sharing stimulus, plus a four-source round-robin instance for wrap cases.
module tb_bp_lce_resp_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [2*W-1:0] a_resp;
  logic [1:0]     a_v, a_rdy, b_rdy;
  logic [W-1:0]   a_out, b_out;
  logic           a_vo, b_vo, a_ready;
  logic [0:0]     a_gid, b_gid;
  logic [4*W-1:0] c_resp;
  logic [3:0]     c_v, c_rdy;
  logic [W-1:0]   c_out;
  logic           c_vo, c_ready;
  logic [1:0]     c_gid;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] exp_rr [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
  logic [W-1:0] exp_fp [4] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
  logic         gid_rr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic         gid_fp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  bp_lce_resp_arbiter #(.num_src_p(2), .resp_width_p(W), .buf_els_p(2), .rr_p(1)) u_rr (
    .clk_i(clk), .reset_i(rst), .resp_i(a_resp), .resp_v_i(a_v), .resp_ready_o(a_rdy),
    .lce_resp_o(a_out), .lce_resp_v_o(a_vo), .lce_resp_ready_i(a_ready), .grant_id_o(a_gid)
  );

  bp_lce_resp_arbiter #(.num_src_p(2), .resp_width_p(W), .buf_els_p(2), .rr_p(0)) u_fp (
    .clk_i(clk), .reset_i(rst), .resp_i(a_resp), .resp_v_i(a_v), .resp_ready_o(b_rdy),
    .lce_resp_o(b_out), .lce_resp_v_o(b_vo), .lce_resp_ready_i(a_ready), .grant_id_o(b_gid)
  );

  bp_lce_resp_arbiter #(.num_src_p(4), .resp_width_p(W), .buf_els_p(2), .rr_p(1)) u_rr4 (
    .clk_i(clk), .reset_i(rst), .resp_i(c_resp), .resp_v_i(c_v), .resp_ready_o(c_rdy),
    .lce_resp_o(c_out), .lce_resp_v_o(c_vo), .lce_resp_ready_i(c_ready), .grant_id_o(c_gid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_v = '0; c_v = '0; a_ready = 1'b0; c_ready = 1'b0; a_resp = '0; c_resp = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset values, single packet latency
    a_v = '0; c_v = '0; a_ready = 1'b0; c_ready = 1'b0; a_resp = '0; c_resp = '0;
    rst = 1'b1;
    step();
    check_eq("rst_rdy", a_rdy, 2'b00);
    check_eq("rst_v", a_vo, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_rdy", a_rdy, 2'b11);
    a_v = 2'b01; a_resp[7:0] = 8'hA1; a_ready = 1'b1;
    step();
    a_v = 2'b00;
    check_eq("t1_v", a_vo, 1'b1);
    check_eq("t1_pkt", a_out, 8'hA1);
    check_eq("t1_gid", a_gid, 1'b0);
    check_eq("t1_rdy", a_rdy, 2'b11);
    step();
    check_eq("t1_drain", a_vo, 1'b0);

    // 2: interleave under rr, source order under fixed priority
    do_reset();
    a_v = 2'b11; a_resp = {8'hB0, 8'hA0};
    step();
    a_resp = {8'hB1, 8'hA1};
    step();
    a_v = 2'b00;
    check_eq("both_full", a_rdy, 2'b00);
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_pkt", a_out, exp_rr[k]);
      check_eq("rr_gid", a_gid, gid_rr[k]);
      check_eq("fp_pkt", b_out, exp_fp[k]);
      check_eq("fp_gid", b_gid, gid_fp[k]);
      step();
    end
    check_eq("rr_empty", a_vo, 1'b0);
    check_eq("fp_empty", b_vo, 1'b0);

    // 3: grant locked while downstream stalls
    do_reset();
    a_v = 2'b10; a_resp[15:8] = 8'hB0;
    step();
    a_v = 2'b01; a_resp[7:0] = 8'hA0;
    step();
    a_v = 2'b00;
    for (int k = 0; k < 5; k++) begin
      check_eq("lock_v", a_vo, 1'b1);
      check_eq("lock_pkt", a_out, 8'hB0);
      check_eq("lock_gid", a_gid, 1'b1);
      check_eq("lock_fp_pkt", b_out, 8'hB0);
      step();
    end
    a_ready = 1'b1;
    step();
    check_eq("unlock_pkt", a_out, 8'hA0);
    check_eq("unlock_gid", a_gid, 1'b0);
    check_eq("unlock_fp_pkt", b_out, 8'hA0);
    step();
    check_eq("unlock_empty", a_vo, 1'b0);

    // 4: full FIFO back-pressure
    do_reset();
    a_v = 2'b01; a_resp[7:0] = 8'hC0;
    step();
    check_eq("full_rdy1", a_rdy[0], 1'b1);
    a_resp[7:0] = 8'hC1;
    step();
    check_eq("full_rdy2", a_rdy[0], 1'b0);
    a_resp[7:0] = 8'hC2;
    step();
    check_eq("full_held", a_rdy[0], 1'b0);
    check_eq("full_head", a_out, 8'hC0);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check_eq("full_reopen", a_rdy[0], 1'b1);
    check_eq("full_next", a_out, 8'hC1);
    step();
    a_v = 2'b00;
    check_eq("full_again", a_rdy[0], 1'b0);
    a_ready = 1'b1;
    step();
    check_eq("full_c2", a_out, 8'hC2);
    step();
    check_eq("full_drain", a_vo, 1'b0);

    // 5: round-robin wrap on four sources
    do_reset();
    c_ready = 1'b1;
    c_v = 4'b0101; c_resp[7:0] = 8'hD0; c_resp[23:16] = 8'hD2;
    step();
    c_v = 4'b0000;
    check_eq("wrap_gid0", c_gid, 2'd0);
    check_eq("wrap_pkt0", c_out, 8'hD0);
    step();
    check_eq("wrap_gid2", c_gid, 2'd2);
    check_eq("wrap_pkt2", c_out, 8'hD2);
    step();
    check_eq("wrap_empty", c_vo, 1'b0);
    c_v = 4'b1001; c_resp[7:0] = 8'hE0; c_resp[31:24] = 8'hE3;
    step();
    c_v = 4'b0000;
    check_eq("wrap_gid3", c_gid, 2'd3);
    check_eq("wrap_pkt3", c_out, 8'hE3);
    step();
    check_eq("wrap_gid0b", c_gid, 2'd0);
    check_eq("wrap_pkt0b", c_out, 8'hE0);

    // 6: reset with packets buffered
    do_reset();
    a_v = 2'b01; a_resp[7:0] = 8'hF0;
    step();
    a_resp[7:0] = 8'hF1;
    step();
    a_v = 2'b00;
    check_eq("mid_v", a_vo, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_v", a_vo, 1'b0);
    check_eq("mid_rst_rdy", a_rdy, 2'b00);
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_post_v", a_vo, 1'b0);
    check_eq("mid_post_rdy", a_rdy, 2'b11);
    a_v = 2'b11; a_resp = {8'h61, 8'h60}; a_ready = 1'b1;
    step();
    a_v = 2'b00;
    check_eq("mid_gid0", a_gid, 1'b0);
    check_eq("mid_pkt0", a_out, 8'h60);
    step();
    check_eq("mid_gid1", a_gid, 1'b1);
    check_eq("mid_pkt1", a_out, 8'h61);
    step();
    check_eq("mid_empty", a_vo, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
